// File: rtl/progmem_pkg.sv
// Shared definitions for the writable program memory: FSM state encoding,
// boot-program opcodes and the power-up image loaded into the RAM array.
package progmem_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int BOOT_LEN = 5;

  // Boot program at word 0 upward; every word not listed powers up as NOP.
  localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
    {OP_LOAD, 12'hE08},
    {OP_LOAD, 12'h000},
    {OP_MOV,  12'h1C0},
    {OP_OUT,  12'h600},
    {OP_JMP,  12'h000}
  };

endpackage

// File: rtl/prog_ram.sv
// Single-write, single-registered-read RAM holding the program. The array
// powers up with the boot image and is never touched by reset; only the
// read-data register is reset.
module prog_ram
  import progmem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [INST_W-1:0] mem_t [DEPTH];

  // Builds the power-up contents; the size cast zero-extends or truncates
  // the 16-bit boot words to the configured instruction width.
  function automatic mem_t boot_contents();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = '0;
    end
    for (int i = 0; i < BOOT_LEN; i++) begin
      if (i < DEPTH) begin
        img[i] = INST_W'(BOOT_IMAGE[i]);
      end
    end
    return img;
  endfunction

  mem_t mem = boot_contents();

  logic [INST_W-1:0] rd_data_q;
  logic [INST_W-1:0] rd_data_d;

  // Write port: one word per enabled cycle, no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Next read data: capture on request, otherwise hold the last word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[raddr];
    end
  end

  // Registered read output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/program_mem.sv
// Writable program memory for the fetch stage: a registered fetch port plus
// a valid/ready load port that rewrites the program from word 0 upward.
// Optional macro PROGMEM_CHECKSUM_EN adds load_csum, the running sum of the
// words accepted since the last load_start.
module program_mem
  import progmem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [INST_W-1:0] fetch_inst,
  output logic              fetch_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [INST_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
`ifdef PROGMEM_CHECKSUM_EN
  output logic [INST_W-1:0] load_csum,
`endif
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              ram_we;
  logic              ram_rd_en;
  logic              beat_accept;
  logic              beat_final;
`ifdef PROGMEM_CHECKSUM_EN
  logic [INST_W-1:0] csum_q, csum_d;
`endif

  // Load FSM next-state: load_start wins over fetch and over any beat, and a
  // load ends on load_last or on the beat that fills the top word.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    busy_d        = busy_q;
    load_done_d   = 1'b0;
    fetch_valid_d = 1'b0;
    ram_we        = 1'b0;
    ram_rd_en     = 1'b0;
    beat_accept   = 1'b0;
    beat_final    = 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          busy_d  = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
          csum_d  = '0;
`endif
        end else begin
          ram_rd_en     = fetch_req;
          fetch_valid_d = fetch_req;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          ptr_d  = '0;
`ifdef PROGMEM_CHECKSUM_EN
          csum_d = '0;
`endif
        end else if (load_valid && busy_q) begin
          beat_accept = 1'b1;
          beat_final  = load_last || (ptr_q == PTR_LAST);
          ram_we      = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
          csum_d      = csum_q + load_data;
`endif
          if (beat_final) begin
            state_d     = ST_RUN;
            busy_d      = 1'b0;
            load_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      ptr_q         <= '0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
`ifdef PROGMEM_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (ptr_q),
    .wdata   (load_data),
    .rd_en   (ram_rd_en),
    .raddr   (fetch_addr),
    .rd_data (fetch_inst)
  );

  assign fetch_valid = fetch_valid_q;
  assign load_ready  = busy_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
`ifdef PROGMEM_CHECKSUM_EN
  assign load_csum   = csum_q;
`endif

endmodule

// File: tb/tb_program_mem.sv
// Self-checking bench for program_mem: a bench-side memory model predicts
// every fetch, expected words are queued when a fetch is driven and popped
// when fetch_valid returns them.
module tb_program_mem;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [3:0]  fetch_addr;
  logic [15:0] fetch_inst;
  logic        fetch_valid;
  logic        load_start;
  logic        load_valid;
  logic        load_last;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        busy;
`ifdef PROGMEM_CHECKSUM_EN
  logic [15:0] load_csum;
  logic [15:0] csum_model;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [16];
  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  int          done_count;

  program_mem #(
    .ADDR_W (4),
    .INST_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_inst  (fetch_inst),
    .fetch_valid (fetch_valid),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
`ifdef PROGMEM_CHECKSUM_EN
    .load_csum   (load_csum),
`endif
    .busy        (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch request and queue the word the model says it must return.
  task automatic drive_fetch(input logic [3:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    exp_q.push_back(model_mem[addr]);
  endtask

  // Drive one load beat; the model records it as accepted.
  task automatic drive_beat(input logic [3:0] addr, input logic [15:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    model_mem[addr] = data;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = csum_model + data;
`endif
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    fetch_addr = 4'd0;
    #3;
    checks++; if (fetch_inst !== 16'h0000) begin errors++; $display("[TB] FAIL reset_inst got %h want 0000", fetch_inst); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", fetch_valid); end
    checks++; if (busy !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got busy=%b ready=%b want 0/0", busy, load_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", load_done); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_boot_fetch();
    for (int a = 0; a < 6; a++) begin
      drive_fetch(4'(a));
      step();
      exp_word = exp_q.pop_front();
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL boot_valid addr %0d got %b want 1", a, fetch_valid); end
      checks++; if (fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL boot_inst addr %0d got %h want %h", a, fetch_inst, exp_word); end
    end
    fetch_req = 1'b0;
    step();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got %b want 0", fetch_valid); end
    checks++; if (fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL idle_hold got %h want %h", fetch_inst, exp_word); end
  endtask

  task automatic test_short_load();
    logic [15:0] beats [3];
    beats[0] = 16'hAAAA; beats[1] = 16'h5555; beats[2] = 16'h1234;
    load_start = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = 16'h0000;
`endif
    step();
    load_start = 1'b0;
    checks++; if (busy !== 1'b1 || load_ready !== 1'b1) begin errors++; $display("[TB] FAIL short_enter got busy=%b ready=%b want 1/1", busy, load_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(4'(i), beats[i], i == 2);
      step();
      if (i < 2) begin
        checks++; if (load_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL short_mid beat %0d got done=%b busy=%b want 0/1", i, load_done, busy); end
      end else begin
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL short_done got %b want 1", load_done); end
        checks++; if (busy !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("[TB] FAIL short_exit got busy=%b ready=%b want 0/0", busy, load_ready); end
`ifdef PROGMEM_CHECKSUM_EN
        checks++; if (load_csum !== csum_model) begin errors++; $display("[TB] FAIL short_csum got %h want %h", load_csum, csum_model); end
`endif
      end
    end
    idle_inputs();
    for (int a = 0; a < 4; a++) begin
      drive_fetch(4'(a));
      step();
      if (a == 0) begin
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL short_pulse got %b want 0", load_done); end
      end
      exp_word = exp_q.pop_front();
      checks++; if (fetch_valid !== 1'b1 || fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL short_fetch addr %0d got v=%b %h want v=1 %h", a, fetch_valid, fetch_inst, exp_word); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    load_start = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = 16'h0000;
`endif
    step();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_beat(4'(i), 16'h0100 + 16'(i), 1'b0);
      step();
      if (i < 15) begin
        checks++; if (load_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL full_mid beat %0d got done=%b busy=%b want 0/1", i, load_done, busy); end
      end else begin
        checks++; if (load_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL full_done got done=%b busy=%b want 1/0", load_done, busy); end
`ifdef PROGMEM_CHECKSUM_EN
        checks++; if (load_csum !== csum_model) begin errors++; $display("[TB] FAIL full_csum got %h want %h", load_csum, csum_model); end
`endif
      end
    end
    load_valid = 1'b1;
    load_data  = 16'hDEAD;
    load_last  = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready17 got %b want 0", load_ready); end
    step();
    checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL full_after got done=%b busy=%b want 0/0", load_done, busy); end
    idle_inputs();
    drive_fetch(4'd15);
    step();
    exp_word = exp_q.pop_front();
    checks++; if (fetch_valid !== 1'b1 || fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL full_fetch15 got v=%b %h want v=1 %h", fetch_valid, fetch_inst, exp_word); end
    drive_fetch(4'd0);
    step();
    exp_word = exp_q.pop_front();
    checks++; if (fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL full_fetch0 got %h want %h", fetch_inst, exp_word); end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_start_priority();
    fetch_req  = 1'b1;
    fetch_addr = 4'd3;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL prio_enter got v=%b busy=%b want 0/1", fetch_valid, busy); end
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 4'(i);
      step();
      checks++; if (fetch_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL prio_hold cyc %0d got v=%b busy=%b want 0/1", i, fetch_valid, busy); end
    end
    drive_beat(4'd0, 16'h7777, 1'b1);
    step();
    checks++; if (fetch_valid !== 1'b0 || load_done !== 1'b1) begin errors++; $display("[TB] FAIL prio_exit got v=%b done=%b want 0/1", fetch_valid, load_done); end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int a = 0; a < 2; a++) begin
      drive_fetch(4'(a));
      step();
      exp_word = exp_q.pop_front();
      checks++; if (fetch_valid !== 1'b1 || fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL prio_fetch addr %0d got v=%b %h want v=1 %h", a, fetch_valid, fetch_inst, exp_word); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    drive_beat(4'd0, 16'hC0DE, 1'b0);
    step();
    drive_beat(4'd1, 16'hBEEF, 1'b0);
    step();
    load_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got busy=%b want 1", busy); end
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin errors++; $display("[TB] FAIL arst_status got busy=%b ready=%b done=%b want 0/0/0", busy, load_ready, load_done); end
    checks++; if (fetch_valid !== 1'b0 || fetch_inst !== 16'h0000) begin errors++; $display("[TB] FAIL arst_fetch got v=%b %h want v=0 0000", fetch_valid, fetch_inst); end
    #1;
    rst = 1'b0;
    step();
    for (int a = 0; a < 3; a++) begin
      drive_fetch(4'(a));
      step();
      exp_word = exp_q.pop_front();
      checks++; if (fetch_valid !== 1'b1 || fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL arst_read addr %0d got v=%b %h want v=1 %h", a, fetch_valid, fetch_inst, exp_word); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_restart();
    done_count = 0;
    load_start = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = 16'h0000;
`endif
    step();
    load_start = 1'b0;
    drive_beat(4'd0, 16'h1111, 1'b0);
    step();
    if (load_done === 1'b1) done_count++;
    drive_beat(4'd1, 16'h2222, 1'b0);
    step();
    if (load_done === 1'b1) done_count++;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h3333;
    load_last  = 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = 16'h0000;
`endif
    step();
    load_start = 1'b0;
    if (load_done === 1'b1) done_count++;
    checks++; if (busy !== 1'b1 || load_done !== 1'b0) begin errors++; $display("[TB] FAIL restart_abort got busy=%b done=%b want 1/0", busy, load_done); end
    drive_beat(4'd0, 16'h9999, 1'b1);
    step();
    if (load_done === 1'b1) done_count++;
    checks++; if (load_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_done got done=%b busy=%b want 1/0", load_done, busy); end
`ifdef PROGMEM_CHECKSUM_EN
    checks++; if (load_csum !== csum_model) begin errors++; $display("[TB] FAIL restart_csum got %h want %h", load_csum, csum_model); end
`endif
    idle_inputs();
    for (int a = 0; a < 3; a++) begin
      drive_fetch(4'(a));
      step();
      if (load_done === 1'b1) done_count++;
      exp_word = exp_q.pop_front();
      checks++; if (fetch_valid !== 1'b1 || fetch_inst !== exp_word) begin errors++; $display("[TB] FAIL restart_fetch addr %0d got v=%b %h want v=1 %h", a, fetch_valid, fetch_inst, exp_word); end
    end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL restart_pulses got %0d want 1", done_count); end
    fetch_req = 1'b0;
    step();
  endtask

  // Test sequence and summary.
  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    model_mem[0] = 16'h1E08;
    model_mem[1] = 16'h1000;
    model_mem[2] = 16'hE1C0;
    model_mem[3] = 16'hF600;
    model_mem[4] = 16'h8000;
`ifdef PROGMEM_CHECKSUM_EN
    csum_model = 16'h0000;
`endif
    test_reset();
    test_boot_fetch();
    test_short_load();
    test_full_load();
    test_start_priority();
    test_async_reset();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
